// File: rtl/mm_bus_pkg.sv
// Shared types and helpers for the memory-mapped I/O bus controller.
// Region 0 is internal data memory; regions 1..num_ch map to channels 0..num_ch-1.
package mm_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_INTERNAL,
        RGN_MAPPED,
        RGN_UNMAPPED
    } rgn_cls_t;

    localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

    function automatic rgn_cls_t region_class(input int unsigned region,
                                              input int unsigned num_ch);
        if (region == 0) begin
            return RGN_INTERNAL;
        end else if (region <= num_ch) begin
            return RGN_MAPPED;
        end
        return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/mm_bus_ctrl_if.sv
// CPU-side and peripheral-side signals of the bus controller.
// The controller takes the slave modport; the CPU/peripheral environment takes master.
interface mm_bus_ctrl_if #(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int NUM_CH      = 4,
    parameter int REGION_BITS = 3
);
    logic [AW-1:0]        cpu_addr;
    logic [DW-1:0]        cpu_wdata;
    logic                 cpu_re;
    logic                 cpu_we;
    logic [DW-1:0]        cpu_rdata;
    logic                 cpu_stall;
    logic [AW-1:0]        bus_addr;
    logic [DW-1:0]        bus_wdata;
    logic [NUM_CH-1:0]    ch_sel;
    logic                 ch_re;
    logic                 ch_we;
    logic [NUM_CH*DW-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_rdy;
    logic                 err_clr;
    logic                 err_unmapped;
    logic                 err_timeout;
    logic [REGION_BITS-1:0] err_ch;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_re, cpu_we, ch_rdata, ch_rdy, err_clr,
        output cpu_rdata, cpu_stall, bus_addr, bus_wdata, ch_sel, ch_re, ch_we,
               err_unmapped, err_timeout, err_ch
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_re, cpu_we, ch_rdata, ch_rdy, err_clr,
        input  cpu_rdata, cpu_stall, bus_addr, bus_wdata, ch_sel, ch_re, ch_we,
               err_unmapped, err_timeout, err_ch
    );

endinterface

// File: rtl/mm_region_dec.sv
// Combinational address decode: top REGION_BITS bits select internal memory,
// a peripheral channel (one-hot), or an unmapped region.
module mm_region_dec
    import mm_bus_pkg::*;
#(
    parameter int AW          = 16,
    parameter int NUM_CH      = 4,
    parameter int REGION_BITS = 3
) (
    input  logic [AW-1:0]          addr_i,
    output logic [REGION_BITS-1:0] region_o,
    output logic                   internal_o,
    output logic                   mapped_o,
    output logic                   unmapped_o,
    output logic [NUM_CH-1:0]      ch_onehot_o
);

    rgn_cls_t cls;

    always_comb begin
        region_o    = addr_i[AW-1 -: REGION_BITS];
        cls         = region_class(32'(region_o), NUM_CH);
        internal_o  = (cls == RGN_INTERNAL);
        mapped_o    = (cls == RGN_MAPPED);
        unmapped_o  = (cls == RGN_UNMAPPED);
        ch_onehot_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_onehot_o[i] = (32'(region_o) == 32'(i + 1));
        end
    end

endmodule

// File: rtl/mm_bus_ctrl.sv
// Memory-mapped I/O bus controller: channel select, ready-based wait states
// with CPU stall, access timeout and sticky error reporting.
module mm_bus_ctrl
    import mm_bus_pkg::*;
#(
    parameter int             DW          = 16,
    parameter int             AW          = 16,
    parameter int             NUM_CH      = 4,
    parameter int             REGION_BITS = 3,
    parameter int             TIMEOUT     = 64,
    parameter logic [DW-1:0]  ERR_DATA    = DW'(ERR_DATA_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    mm_bus_ctrl_if.slave  bus
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t                 state_q;
    logic [AW-1:0]          addr_q;
    logic [DW-1:0]          wdata_q;
    logic [DW-1:0]          rdata_q;
    logic                   write_q;
    logic [REGION_BITS-1:0] region_q;
    logic [NUM_CH-1:0]      ch_sel_q;
    logic                   re_q;
    logic                   we_q;
    logic [CW-1:0]          cnt_q;
    logic                   err_unm_q;
    logic                   err_to_q;
    logic [REGION_BITS-1:0] err_ch_q;

    logic [REGION_BITS-1:0] dec_region;
    logic                   dec_internal;
    logic                   dec_mapped;
    logic                   dec_unmapped;
    logic [NUM_CH-1:0]      dec_onehot;

    logic                   ext_req;
    logic                   rdy_sel;
    logic [DW-1:0]          rdata_sel;
    logic [CW-1:0]          cnt_inc;
    logic                   tmo_hit;
    logic                   set_unm;
    logic                   set_to;

    mm_region_dec #(
        .AW          (AW),
        .NUM_CH      (NUM_CH),
        .REGION_BITS (REGION_BITS)
    ) u_dec (
        .addr_i      (bus.cpu_addr),
        .region_o    (dec_region),
        .internal_o  (dec_internal),
        .mapped_o    (dec_mapped),
        .unmapped_o  (dec_unmapped),
        .ch_onehot_o (dec_onehot)
    );

    // Ready and read data only ever come from the channel currently selected.
    always_comb begin
        ext_req   = (bus.cpu_re | bus.cpu_we) & ~dec_internal;
        rdy_sel   = |(bus.ch_rdy & ch_sel_q);
        rdata_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rdata_sel = rdata_sel | ({DW{ch_sel_q[i]}} & bus.ch_rdata[i*DW +: DW]);
        end
        cnt_inc = cnt_q + 1'b1;
        tmo_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
        set_unm = (state_q == IDLE) && ext_req && dec_unmapped;
        set_to  = (state_q == ACCESS) && !rdy_sel && tmo_hit;
    end

    assign bus.cpu_stall    = ((state_q == IDLE) && ext_req) || (state_q == ACCESS);
    assign bus.cpu_rdata    = rdata_q;
    assign bus.bus_addr     = addr_q;
    assign bus.bus_wdata    = wdata_q;
    assign bus.ch_sel       = ch_sel_q;
    assign bus.ch_re        = re_q;
    assign bus.ch_we        = we_q;
    assign bus.err_unmapped = err_unm_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_ch       = err_ch_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            write_q   <= 1'b0;
            region_q  <= '0;
            ch_sel_q  <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            err_unm_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ch_q  <= '0;
        end else begin
            // A flag being set in the same cycle as err_clr stays set.
            err_unm_q <= set_unm | (err_unm_q & ~bus.err_clr);
            err_to_q  <= set_to  | (err_to_q  & ~bus.err_clr);
            if (set_unm) begin
                err_ch_q <= dec_region;
            end else if (set_to) begin
                err_ch_q <= region_q;
            end

            case (state_q)
                IDLE: begin
                    if (ext_req) begin
                        addr_q   <= bus.cpu_addr;
                        wdata_q  <= bus.cpu_wdata;
                        write_q  <= bus.cpu_we;
                        region_q <= dec_region;
                        cnt_q    <= '0;
                        if (dec_mapped) begin
                            ch_sel_q <= dec_onehot;
                            re_q     <= ~bus.cpu_we;
                            we_q     <= bus.cpu_we;
                            state_q  <= ACCESS;
                        end else begin
                            if (!bus.cpu_we) begin
                                rdata_q <= ERR_DATA;
                            end
                            state_q <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    if (rdy_sel || tmo_hit) begin
                        if (!write_q) begin
                            rdata_q <= rdy_sel ? rdata_sel : ERR_DATA;
                        end
                        ch_sel_q <= '0;
                        re_q     <= 1'b0;
                        we_q     <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_bus_ctrl.sv
// Scoreboard bench for mm_bus_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares them when the access completes.
module tb_mm_bus_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int NCH = 4;
    localparam int RB  = 3;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mm_bus_ctrl_if #(.DW(DW), .AW(AW), .NUM_CH(NCH), .REGION_BITS(RB)) bus ();

    mm_bus_ctrl #(
        .DW          (DW),
        .AW          (AW),
        .NUM_CH      (NCH),
        .REGION_BITS (RB),
        .TIMEOUT     (TMO),
        .ERR_DATA    (16'hDEAD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        int          stall;
        logic [3:0]  sel;
        int          sel_cyc;
        int          re_cyc;
        int          we_cyc;
        logic        chk_wd;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        unm;
        logic        tmo;
        logic [2:0]  ech;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input int stall, input logic [3:0] sel,
                                input int sel_cyc, input int re_cyc, input int we_cyc,
                                input logic chk_wd, input logic [15:0] wd,
                                input logic [15:0] rd, input logic unm, input logic tmo,
                                input logic [2:0] ech);
        exp_t e;
        e.id = id; e.stall = stall; e.sel = sel; e.sel_cyc = sel_cyc;
        e.re_cyc = re_cyc; e.we_cyc = we_cyc; e.chk_wd = chk_wd; e.wdata = wd;
        e.rdata = rd; e.unm = unm; e.tmo = tmo; e.ech = ech;
        return e;
    endfunction

    // Monitor: accumulates per-access observations, compares on the first
    // non-stalled cycle of an active request (DONE, or an internal access).
    int          m_stall, m_sel_cyc, m_re, m_we;
    logic [3:0]  m_sel;
    logic [15:0] m_wd;

    initial begin
        exp_t e;
        m_stall = 0; m_sel_cyc = 0; m_re = 0; m_we = 0; m_sel = '0; m_wd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_stall = 0; m_sel_cyc = 0; m_re = 0; m_we = 0; m_sel = '0; m_wd = '0;
            end else if (bus.cpu_re || bus.cpu_we) begin
                m_stall   += int'(bus.cpu_stall);
                m_sel      = m_sel | bus.ch_sel;
                m_sel_cyc += int'(bus.ch_sel != '0);
                m_re      += int'(bus.ch_re);
                m_we      += int'(bus.ch_we);
                if (bus.ch_we) m_wd = bus.bus_wdata;
                if (!bus.cpu_stall) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_done: completion seen with empty scoreboard");
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("v%0d_stall_cycles", e.id), m_stall, e.stall);
                        chk($sformatf("v%0d_ch_sel", e.id), 32'(m_sel), 32'(e.sel));
                        chk($sformatf("v%0d_sel_cycles", e.id), m_sel_cyc, e.sel_cyc);
                        chk($sformatf("v%0d_re_cycles", e.id), m_re, e.re_cyc);
                        chk($sformatf("v%0d_we_cycles", e.id), m_we, e.we_cyc);
                        if (e.chk_wd) chk($sformatf("v%0d_bus_wdata", e.id), 32'(m_wd), 32'(e.wdata));
                        chk($sformatf("v%0d_cpu_rdata", e.id), 32'(bus.cpu_rdata), 32'(e.rdata));
                        chk($sformatf("v%0d_err_unmapped", e.id), 32'(bus.err_unmapped), 32'(e.unm));
                        chk($sformatf("v%0d_err_timeout", e.id), 32'(bus.err_timeout), 32'(e.tmo));
                        chk($sformatf("v%0d_err_ch", e.id), 32'(bus.err_ch), 32'(e.ech));
                    end
                    m_stall = 0; m_sel_cyc = 0; m_re = 0; m_we = 0; m_sel = '0; m_wd = '0;
                end
            end
        end
    end

    // Driver: holds the request until stall drops, raising the selected
    // channel's ready after rdy_wait ACCESS cycles (negative: never).
    task automatic run_access(input int id, input logic [15:0] addr, input logic [15:0] wdata,
                              input logic re, input logic we, input logic [3:0] rdy_base,
                              input int rdy_wait, input logic clr, input exp_t e);
        int   waited;
        int   acc;
        logic done;
        logic first;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_re    = re;
        bus.cpu_we    = we;
        bus.ch_rdy    = rdy_base;
        bus.err_clr   = clr;
        waited = 0; acc = 0; done = 1'b0; first = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (first) first = 1'b0;
            else bus.err_clr = 1'b0;
            if (!bus.cpu_stall) begin
                done = 1'b1;
            end else begin
                if (bus.ch_sel != '0) begin
                    if (rdy_wait >= 0 && acc >= rdy_wait) bus.ch_rdy = bus.ch_rdy | bus.ch_sel;
                    acc++;
                end
                waited++;
                if (waited > 200) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL v%0d_stall_bound: stall still high after %0d cycles, required release", id, waited);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.cpu_re  = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.ch_rdy  = '0;
        bus.err_clr = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_re    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.ch_rdy    = '0;
        bus.err_clr   = 1'b0;
        bus.ch_rdata  = {16'h4444, 16'h2222, 16'h1234, 16'h1111};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_bus_addr", 32'(bus.bus_addr), 32'd0);
        chk("rst_err_flags", {30'd0, bus.err_unmapped, bus.err_timeout}, 32'd0);

        run_access(1, 16'h4010, 16'h0000, 1'b1, 1'b0, 4'b0010, 0, 1'b0,
                   mk(1, 2, 4'b0010, 1, 1, 0, 1'b0, 16'h0, 16'h1234, 1'b0, 1'b0, 3'd0));
        run_access(2, 16'h2004, 16'hBEEF, 1'b0, 1'b1, 4'b0000, 3, 1'b0,
                   mk(2, 5, 4'b0001, 4, 0, 4, 1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b0, 3'd0));
        run_access(3, 16'h0100, 16'h0000, 1'b1, 1'b0, 4'b0000, 0, 1'b0,
                   mk(3, 0, 4'b0000, 0, 0, 0, 1'b0, 16'h0, 16'h1234, 1'b0, 1'b0, 3'd0));
        run_access(4, 16'h2000, 16'h5A5A, 1'b1, 1'b1, 4'b0001, 0, 1'b0,
                   mk(4, 2, 4'b0001, 1, 0, 1, 1'b1, 16'h5A5A, 16'h1234, 1'b0, 1'b0, 3'd0));
        run_access(5, 16'hA000, 16'h0000, 1'b1, 1'b0, 4'b0000, 0, 1'b0,
                   mk(5, 1, 4'b0000, 0, 0, 0, 1'b0, 16'h0, 16'hDEAD, 1'b1, 1'b0, 3'd5));
        run_access(6, 16'h8000, 16'h0000, 1'b1, 1'b0, 4'b0111, -1, 1'b0,
                   mk(6, 65, 4'b1000, 64, 64, 0, 1'b0, 16'h0, 16'hDEAD, 1'b1, 1'b1, 3'd4));

        pulse_clr();
        @(negedge clk);
        chk("clr_err_unmapped", 32'(bus.err_unmapped), 32'd0);
        chk("clr_err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("clr_err_ch_kept", 32'(bus.err_ch), 32'd4);

        run_access(7, 16'hE000, 16'h7777, 1'b0, 1'b1, 4'b0000, 0, 1'b1,
                   mk(7, 1, 4'b0000, 0, 0, 0, 1'b0, 16'h0, 16'hDEAD, 1'b1, 1'b0, 3'd7));
        pulse_clr();
        run_access(8, 16'h6000, 16'h0000, 1'b1, 1'b0, 4'b0000, 2, 1'b0,
                   mk(8, 4, 4'b0100, 3, 3, 0, 1'b0, 16'h0, 16'h2222, 1'b0, 1'b0, 3'd7));

        // Reset two cycles into an ACCESS that never sees ready.
        @(posedge clk); #1;
        bus.cpu_addr = 16'h6000;
        bus.cpu_re   = 1'b1;
        bus.ch_rdy   = '0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_ch_sel", 32'(bus.ch_sel), 32'h4);
        chk("pre_rst_ch_re", 32'(bus.ch_re), 32'd1);
        @(posedge clk); #1;
        rst        = 1'b1;
        bus.cpu_re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ch_sel", 32'(bus.ch_sel), 32'd0);
        chk("post_rst_strobes", {30'd0, bus.ch_re, bus.ch_we}, 32'd0);
        chk("post_rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("post_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("post_rst_err_ch", 32'(bus.err_ch), 32'd0);

        bus.ch_rdata[2*DW +: DW] = 16'h3333;
        run_access(9, 16'h6000, 16'h0000, 1'b1, 1'b0, 4'b0100, 0, 1'b0,
                   mk(9, 2, 4'b0100, 1, 1, 0, 1'b0, 16'h0, 16'h3333, 1'b0, 1'b0, 3'd0));

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
